spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: SS_n  input  1  slave select, active low; low = frame in progress.
REQ-005 SHALL have port: MOSI  input  1  serial data in, MSB first, sampled every clk while SS_n low.
REQ-006 SHALL have port: MISO  output  1  serial data out, MSB first.
REQ-007 SHALL have port: rx_data  output  10  parallel word to RAM; [9:8] command, [7:0] address/data.
REQ-008 SHALL have port: rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-009 SHALL have port: tx_data  input  8  read data from RAM.
REQ-010 SHALL have port: tx_valid  input  1  tx_data valid, sampled only in READ_DATA wait phase.

Function
REQ-011 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE: SS_n=0 -> CHK_CMD next cycle; else stay.
REQ-013 CHK_CMD: MOSI captured as rx_data bit 9; MOSI=0 -> WRITE; MOSI=1 and rd_addr_seen=0 -> READ_ADD; MOSI=1 and rd_addr_seen=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA: next 9 MOSI samples shifted in as bits 8..0 via 4-bit bit counter.
REQ-015 Cycle after 9th sample: rx_valid=1 for exactly one cycle, rx_data holds all 10 bits; rx_data held until next word completes.
REQ-016 Command bits forwarded raw; no check that bit 8 matches chosen state.
REQ-017 WRITE: after rx_valid, further MOSI ignored until SS_n=1.
REQ-018 READ_ADD: rx_valid strobe sets rd_addr_seen=1; further MOSI ignored until SS_n=1.
REQ-019 READ_DATA: after rx_valid, wait; first cycle with tx_valid=1 latches tx_data; MISO drives tx_data[7..0], one bit per cycle, starting cycle after latch.
REQ-020 READ_DATA: after 8th bit MISO=0, rd_addr_seen cleared, tx_valid ignored until SS_n=1.
REQ-021 tx_valid in any state/phase other than REQ-019 wait SHALL be ignored.
REQ-022 MISO SHALL be 0 whenever not shifting read data.
REQ-023 SS_n=1 in any non-IDLE state -> IDLE next cycle; bit counter cleared; no rx_valid for partial word; MISO=0; rd_addr_seen unchanged unless REQ-020 completed.
REQ-024 SS_n=1 and frame completion same cycle: rx_valid strobe still issued, state -> IDLE.
REQ-025 SS_n high for one cycle between frames SHALL be sufficient for a new frame.

Reset
REQ-026 rst=1: state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0, tx shift register=0.
REQ-027 Reset SHALL override SS_n, MOSI, tx_valid in the same cycle, including mid-frame.

Structure
REQ-028 Package spi_pkg SHALL hold state enum, RX_W=10, TX_W=8, command constants (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11).
REQ-029 One sub-module SHALL exist: spi_tx_serializer (load 8 bits, shift MSB first, done flag).
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Reset mid-frame: rst=1 after 5 bits -> next cycle IDLE, rx_valid=0, MISO=0, rd_addr_seen=0.
REQ-032 Write address: SS_n=0, MOSI 00_1010_0101 -> one rx_valid, rx_data=10'h0A5, MISO stays 0.
REQ-033 Read sequence: frame 10_0000_0011 (rd_addr_seen->1), SS_n=1, frame 11_xxxx_xxxx, tx_valid=1 tx_data=8'hC3 after 3 cycles -> MISO 1,1,0,0,0,0,1,1, rd_addr_seen->0.
REQ-034 Abort: SS_n=1 after 6 bits -> no rx_valid, IDLE next cycle; following full frame 01_1111_0000 -> rx_data=10'h1F0.
REQ-035 Spurious tx_valid=1 during WRITE and IDLE -> MISO stays 0, no state change.
REQ-036 Read data without prior read address (rd_addr_seen=0), MOSI 11_0000_0000 -> READ_ADD path, rx_data=10'h300, rd_addr_seen->1, MISO stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM states, word widths
// and the two-bit command codes carried in rx_data[9:8].
package spi_pkg;

  localparam int RX_W = 10;
  localparam int TX_W = 8;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial shifter for read data: loads a byte and presents it on
// miso MSB first, one bit per cycle, then returns miso to 0 and flags done.
import spi_pkg::*;

module spi_tx_serializer (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic [TX_W-1:0] data,
  output logic            miso,
  output logic            busy,
  output logic            done,
  output logic            last_bit
);

  logic [TX_W-1:0] sreg;
  logic [3:0]      cnt;

  // High during the cycle the final data bit is on miso.
  assign last_bit = busy && (cnt == 4'(TX_W));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sreg <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      miso <= 1'b0;
    end else if (load) begin
      miso <= data[TX_W-1];
      sreg <= {data[TX_W-2:0], 1'b0};
      cnt  <= 4'd1;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (cnt == 4'(TX_W)) begin
        miso <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        miso <= sreg[TX_W-1];
        sreg <= {sreg[TX_W-2:0], 1'b0};
        cnt  <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a small RAM: deserialises 10-bit command words
// from MOSI and serialises the returned read byte on MISO.
import spi_pkg::*;

module spi_slave (
  input  logic            clk,
  input  logic            rst,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid,
  output state_t          state,
  output logic            rd_addr_seen
);

  state_t          next;
  logic [3:0]      cnt;
  logic [RX_W-2:0] shift;
  logic            in_data;
  logic            word_end;
  logic            sample_bit;
  logic            tx_load;
  logic            tx_busy;
  logic            tx_done;
  logic            tx_last;

  // cnt 0..8 counts data bits still being received; 9 means the word is in.
  assign in_data    = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign word_end   = in_data && (cnt == 4'd8);
  assign sample_bit = in_data && !SS_n && (cnt < 4'd8);

  // tx_valid handshake: no ready signal; tx_valid is only looked at while a
  // READ_DATA word is complete and nothing has been loaded yet this frame.
  // The first cycle it is high there latches tx_data; all others are ignored.
  assign tx_load = (state == READ_DATA) && !SS_n && (cnt == 4'd9)
                   && !tx_busy && !tx_done && tx_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (!SS_n) next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              next = IDLE;
        else if (!MOSI)        next = WRITE;
        else if (rd_addr_seen) next = READ_DATA;
        else                   next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == CHK_CMD)  shift <= {{(RX_W-2){1'b0}}, MOSI};
      else if (sample_bit)   shift <= {shift[RX_W-3:0], MOSI};
      // A word whose last bit arrives as SS_n rises still counts as complete.
      if (word_end) begin
        rx_data  <= {shift, MOSI};
        rx_valid <= 1'b1;
      end
      if (SS_n || state == CHK_CMD) cnt <= '0;
      else if (word_end)            cnt <= 4'd9;
      else if (sample_bit)          cnt <= cnt + 4'd1;
      if (word_end && state == READ_ADD) rd_addr_seen <= 1'b1;
      else if (tx_last)                  rd_addr_seen <= 1'b0;
    end
  end

  spi_tx_serializer u_tx (
    .clk      (clk),
    .rst      (rst),
    .clear    (SS_n),
    .load     (tx_load),
    .data     (tx_data),
    .miso     (MISO),
    .busy     (tx_busy),
    .done     (tx_done),
    .last_bit (tx_last)
  );

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a frame-level timeline model schedules the
// expected strobes, MISO bits and rd_addr_seen changes, checked every cycle.
import spi_pkg::*;

module tb_spi_slave;

  localparam int MAXC = 2048;

  logic            clk = 1'b0;
  logic            rst;
  logic            SS_n;
  logic            MOSI;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;
  state_t          state;
  logic            rd_addr_seen;

  spi_slave dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .state        (state),
    .rd_addr_seen (rd_addr_seen)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // timeline model: events keyed by the cycle in which they become visible
  bit              ev_rst    [MAXC];
  bit              ev_word_v [MAXC];
  bit              ev_seen_v [MAXC];
  bit              ev_seen   [MAXC];
  bit              exp_miso  [MAXC];
  logic [RX_W-1:0] exp_q[$];
  logic [RX_W-1:0] cur_data = '0;
  bit              cur_seen = 1'b0;
  bit              m_seen   = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // scoreboard: compare every cycle against the timeline model
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (ev_rst[cyc]) begin
        cur_data = '0;
        cur_seen = 1'b0;
      end
      if (ev_word_v[cyc] && exp_q.size() > 0) cur_data = exp_q.pop_front();
      if (ev_seen_v[cyc]) cur_seen = ev_seen[cyc];
      check("rx_valid", 32'(rx_valid), 32'(ev_word_v[cyc]));
      check("rx_data", 32'(rx_data), 32'(cur_data));
      check("miso", 32'(MISO), 32'(exp_miso[cyc]));
      check("rd_addr_seen", 32'(rd_addr_seen), 32'(cur_seen));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      SS_n     = 1'b1;
      MOSI     = 1'($urandom_range(0, 1));
      tx_valid = 1'b0;
      step();
    end
  endtask

  // Select at cycle s, bit 9 at s+1, bits 8..0 at s+2..s+10, strobe seen at s+11.
  task automatic send_frame(input logic [9:0] w, input int nbits, input bit last_high);
    int s;
    s        = cyc;
    SS_n     = 1'b0;
    MOSI     = 1'($urandom_range(0, 1));
    tx_valid = 1'b0;
    step();
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[9-i];
      SS_n = (last_high && i == 9) ? 1'b1 : 1'b0;
      step();
    end
    if (nbits == 10) begin
      ev_word_v[s+11] = 1'b1;
      exp_q.push_back(w);
      if (w[9] && !m_seen) begin
        ev_seen_v[s+11] = 1'b1;
        ev_seen[s+11]   = 1'b1;
        m_seen          = 1'b1;
      end
    end
  endtask

  // Called in the READ_DATA wait phase; abort_after < 8 drops SS_n mid-byte.
  task automatic read_data(input int delay, input logic [7:0] d, input int abort_after,
                           output logic [7:0] got);
    int t;
    got = '0;
    repeat (delay) begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom_range(0, 255));
      step();
    end
    t        = cyc;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 8; i++) exp_miso[t+1+i] = d[7-i];
    ev_seen_v[t+9] = 1'b1;
    ev_seen[t+9]   = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      got[7-i] = MISO;
      tx_valid = (i < 2);
      tx_data  = ~d;
      if (i == abort_after) begin
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        for (int c = cyc + 1; c <= t + 9; c++) exp_miso[c] = 1'b0;
        ev_seen_v[t+9] = 1'b0;
        step();
        return;
      end
      step();
    end
    m_seen = 1'b0;
    repeat (3) begin
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      step();
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] got;
    int r;
    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    ev_rst[1] = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_miso", 32'(MISO), 32'h0);
    check("reset_state", 32'(state), 32'(IDLE));

    // spurious tx_valid while idle
    repeat (3) begin
      SS_n     = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'($urandom_range(0, 255));
      step();
    end
    tx_valid = 1'b0;
    check("idle_state_tx_valid", 32'(state), 32'(IDLE));

    // write address, then trailing MOSI and tx_valid noise while selected
    send_frame({WR_ADDR, 8'hA5}, 10, 1'b0);
    repeat (5) begin
      SS_n     = 1'b0;
      MOSI     = 1'($urandom_range(0, 1));
      tx_valid = 1'b1;
      tx_data  = 8'($urandom_range(0, 255));
      step();
    end
    check("wr_addr_word", 32'(rx_data), 32'h0A5);
    check("write_state_hold", 32'(state), 32'(WRITE));
    idle(1);

    // read address then read data with C3 after three wait cycles
    send_frame({RD_ADDR, 8'h03}, 10, 1'b0);
    idle(1);
    check("rd_addr_seen_set", 32'(rd_addr_seen), 32'h1);
    send_frame({RD_DATA, 8'h55}, 10, 1'b0);
    check("read_data_state", 32'(state), 32'(READ_DATA));
    read_data(3, 8'hC3, 8, got);
    check("miso_byte_c3", 32'(got), 32'hC3);
    check("rd_addr_seen_clear", 32'(rd_addr_seen), 32'h0);
    idle(1);

    // read data with no address seen takes the read-address path
    send_frame({RD_DATA, 8'h00}, 10, 1'b0);
    idle(1);
    check("rd_data_as_addr_word", 32'(rx_data), 32'h300);
    check("rd_data_as_addr_seen", 32'(rd_addr_seen), 32'h1);

    // abort after 6 bits, then a full frame after a single high cycle
    send_frame(10'h2AA, 6, 1'b0);
    SS_n = 1'b1;
    step();
    check("abort_state", 32'(state), 32'(IDLE));
    send_frame({WR_DATA, 8'hF0}, 10, 1'b0);
    idle(1);
    check("after_abort_word", 32'(rx_data), 32'h1F0);

    // read data aborted mid-byte keeps rd_addr_seen
    send_frame({RD_DATA, 8'h0F}, 10, 1'b0);
    read_data(0, 8'h96, 3, got);
    check("tx_abort_miso", 32'(MISO), 32'h0);
    check("tx_abort_seen", 32'(rd_addr_seen), 32'h1);
    idle(1);

    // SS_n rises in the same cycle as the final bit
    send_frame({WR_DATA, 8'h5A}, 10, 1'b1);
    check("edge_end_state", 32'(state), 32'(IDLE));
    check("edge_end_valid", 32'(rx_valid), 32'h1);
    check("edge_end_word", 32'(rx_data), 32'h15A);
    idle(2);

    // reset after 5 bits, overriding SS_n/MOSI/tx_valid
    send_frame(10'h3FF, 5, 1'b0);
    r        = cyc;
    rst      = 1'b1;
    SS_n     = 1'b0;
    MOSI     = 1'b1;
    tx_valid = 1'b1;
    ev_rst[r+1] = 1'b1;
    m_seen   = 1'b0;
    step();
    rst      = 1'b0;
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    check("midreset_state", 32'(state), 32'(IDLE));
    check("midreset_valid", 32'(rx_valid), 32'h0);
    check("midreset_miso", 32'(MISO), 32'h0);
    check("midreset_seen", 32'(rd_addr_seen), 32'h0);
    idle(1);

    // recovery frame
    send_frame({WR_ADDR, 8'h3C}, 10, 1'b0);
    idle(2);
    check("recovery_word", 32'(rx_data), 32'h03C);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
